// File: rtl/image_pkg.sv
// Shared types for the image translate stream: FSM states, latched shift config, address sizing.
package image_pkg;

    localparam int SHIFT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRIME,
        ST_EMIT
    } state_t;

    typedef struct packed {
        logic [SHIFT_W-1:0] dx;
        logic [SHIFT_W-1:0] dy;
    } cfg_t;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Frame store: simple dual-port RAM, one write port, one registered read port.
// Latency: read data valid one cycle after rd_en; no backpressure, rd_dat holds while rd_en is low.
module frame_ram #(
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_dat_q;

    // Contents and read register are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat_q <= mem_q[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/image_translate_stream.sv
// Buffers a raster frame and replays it shifted by (dx,dy); IMAGE_TRANSLATE_WRAP_EN enables circular wrap.
// Latency: first output 2 edges after the last input accept; m_ready stalls hold the output register with no bubbles.
module image_translate_stream
    import image_pkg::*;
#(
    parameter int            ROWS = 512,
    parameter int            COLS = 512,
    parameter int            DW   = 8,
    parameter logic [DW-1:0] FILL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [SHIFT_W-1:0] cfg_dx,
    input  logic signed [SHIFT_W-1:0] cfg_dy,
    input  logic                      cfg_wrap,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DW-1:0]             s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DW-1:0]             m_data,
    output logic                      m_last,
    output logic                      busy
);

    localparam int N     = ROWS * COLS;
    localparam int AW    = addr_width(N);
    localparam int DIM   = (ROWS > COLS) ? ROWS : COLS;
    localparam int DIM_W = addr_width(DIM);
    localparam int CW    = ((SHIFT_W > DIM_W + 2) ? SHIFT_W : DIM_W + 2) + 2;

    localparam logic signed [CW-1:0] ROWS_S    = CW'(ROWS);
    localparam logic signed [CW-1:0] COLS_S    = CW'(COLS);
    localparam logic signed [CW-1:0] ROW_LAST  = CW'(ROWS - 1);
    localparam logic signed [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [AW-1:0]        LAST_ADDR = AW'(N - 1);

    state_t                state_q, state_d;
    logic                  s_ready_q, s_ready_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    cfg_t                  cfg_q, cfg_d;
    logic signed [CW-1:0]  iss_r_q, iss_r_d, iss_c_q, iss_c_d;
    logic                  iss_done_q, iss_done_d;
    logic                  rd_vld_q, rd_vld_d, rd_fill_q, rd_fill_d, rd_last_q, rd_last_d;
    logic                  m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [DW-1:0]         m_data_q, m_data_d;

    logic                  ram_we, ram_re, in_acc, load_out, issue;
    logic [DW-1:0]         ram_rd_dat;
    logic [AW-1:0]         rd_addr;
    logic signed [CW-1:0]  src_r, src_c;
    logic                  src_fill, iss_last;

`ifdef IMAGE_TRANSLATE_WRAP_EN
    logic wrap_q, wrap_d;

    // Two fold steps cover any source coordinate produced by |shift| < 2*dimension.
    function automatic logic signed [CW-1:0] wrap_coord(input logic signed [CW-1:0] v,
                                                        input logic signed [CW-1:0] dim);
        logic signed [CW-1:0] t;
        t = v;
        for (int i = 0; i < 2; i++) begin
            if (t[CW-1]) begin
                t = t + dim;
            end else if (t >= dim) begin
                t = t - dim;
            end
        end
        return t;
    endfunction
`else
    logic unused_cfg_wrap;
    assign unused_cfg_wrap = cfg_wrap;
`endif

    always_comb begin : coord
        src_r = iss_r_q - CW'($signed(cfg_q.dy));
        src_c = iss_c_q - CW'($signed(cfg_q.dx));
`ifdef IMAGE_TRANSLATE_WRAP_EN
        if (wrap_q) begin
            src_r = wrap_coord(src_r, ROWS_S);
            src_c = wrap_coord(src_c, COLS_S);
        end
`endif
        src_fill = src_r[CW-1] || (src_r >= ROWS_S) || src_c[CW-1] || (src_c >= COLS_S);
        rd_addr  = src_fill ? '0 : AW'(int'(src_r) * COLS + int'(src_c));
        iss_last = (iss_r_q == ROW_LAST) && (iss_c_q == COL_LAST);
    end

    always_comb begin : fsm
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        cfg_d      = cfg_q;
        iss_r_d    = iss_r_q;
        iss_c_d    = iss_c_q;
        iss_done_d = iss_done_q;
        rd_vld_d   = rd_vld_q;
        rd_fill_d  = rd_fill_q;
        rd_last_d  = rd_last_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
`ifdef IMAGE_TRANSLATE_WRAP_EN
        wrap_d     = wrap_q;
`endif
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        issue      = 1'b0;
        in_acc     = s_valid && s_ready_q;
        load_out   = rd_vld_q && (!m_valid_q || m_ready);

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (in_acc) begin
                    ram_we = 1'b1;
                    if (state_q == ST_IDLE) begin
                        cfg_d.dx = cfg_dx;
                        cfg_d.dy = cfg_dy;
`ifdef IMAGE_TRANSLATE_WRAP_EN
                        wrap_d   = cfg_wrap;
`endif
                    end
                    if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d = '0;
                        state_d   = ST_PRIME;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_PRIME: begin
                issue   = 1'b1;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                issue = !iss_done_q && (!rd_vld_q || load_out);
                if (m_valid_q && m_ready && m_last_q) begin
                    state_d    = ST_IDLE;
                    iss_r_d    = '0;
                    iss_c_d    = '0;
                    iss_done_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // One read in flight at most; a new read is issued only when its slot will be free.
        if (issue) begin
            ram_re    = 1'b1;
            rd_vld_d  = 1'b1;
            rd_fill_d = src_fill;
            rd_last_d = iss_last;
            if (iss_last) begin
                iss_done_d = 1'b1;
            end else if (iss_c_q == COL_LAST) begin
                iss_c_d = '0;
                iss_r_d = iss_r_q + 1'b1;
            end else begin
                iss_c_d = iss_c_q + 1'b1;
            end
        end else if (load_out) begin
            rd_vld_d = 1'b0;
        end

        if (load_out) begin
            m_valid_d = 1'b1;
            m_data_d  = rd_fill_q ? FILL : ram_rd_dat;
            m_last_d  = rd_last_q;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_ready_q  <= 1'b0;
            wr_addr_q  <= '0;
            cfg_q      <= '0;
            iss_r_q    <= '0;
            iss_c_q    <= '0;
            iss_done_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_fill_q  <= 1'b0;
            rd_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
`ifdef IMAGE_TRANSLATE_WRAP_EN
            wrap_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s_ready_q  <= s_ready_d;
            wr_addr_q  <= wr_addr_d;
            cfg_q      <= cfg_d;
            iss_r_q    <= iss_r_d;
            iss_c_q    <= iss_c_d;
            iss_done_q <= iss_done_d;
            rd_vld_q   <= rd_vld_d;
            rd_fill_q  <= rd_fill_d;
            rd_last_q  <= rd_last_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
`ifdef IMAGE_TRANSLATE_WRAP_EN
            wrap_q     <= wrap_d;
`endif
        end
    end

    frame_ram #(
        .DEPTH (N),
        .DW    (DW),
        .AW    (AW)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_addr_q),
        .wr_dat  (s_data),
        .rd_en   (ram_re),
        .rd_addr (rd_addr),
        .rd_dat  (ram_rd_dat)
    );

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/image_translate_stream.md
IMAGE_TRANSLATE_STREAM -- requirements
Module: image_translate_stream

Interface
REQ-001 SHALL have parameter ROWS, default 512, frame height in pixels.
REQ-002 SHALL have parameter COLS, default 512, frame width in pixels.
REQ-003 SHALL have parameter DW, default 8, pixel width in bits.
REQ-004 SHALL have parameter FILL, default 0, DW-bit value for uncovered pixels.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port cfg_dx  input  16 signed  X shift; positive moves content right.
REQ-008 SHALL have port cfg_dy  input  16 signed  Y shift; positive moves content down.
REQ-009 SHALL have port cfg_wrap  input  1  1 = circular wrap, 0 = fill.
REQ-010 SHALL have ports s_valid in 1, s_ready out 1, s_data in DW: raster-order input pixels.
REQ-011 SHALL have ports m_valid out 1, m_ready in 1, m_data out DW, m_last out 1: raster-order output pixels.
REQ-012 SHALL have port busy  output  1  high outside IDLE.

Function
REQ-013 SHALL transfer a beat on either stream only when valid and ready are both high at a clk edge.
REQ-014 SHALL implement states IDLE, LOAD, PRIME, EMIT.
REQ-015 IDLE->LOAD on first accepted input beat; cfg_dx, cfg_dy, cfg_wrap latched on that same edge; later cfg changes ignored until next frame.
REQ-016 LOAD: s_ready=1; accept exactly ROWS*COLS beats into frame RAM at raster address; ->PRIME on the edge accepting the last beat.
REQ-017 PRIME: one cycle issuing the first RAM read; s_ready=0; ->EMIT.
REQ-018 EMIT: s_ready=0; output pixel (r,c) = input (r-dy, c-dx); m_valid first rises 2 edges after the last input accept.
REQ-019 With cfg_wrap=0, SHALL output FILL when r-dy outside 0..ROWS-1 or c-dx outside 0..COLS-1, including |shift| >= dimension.
REQ-020 With cfg_wrap=1, SHALL reduce source coordinates modulo ROWS/COLS; shift magnitudes below 2*dimension SHALL be supported.
REQ-021 m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0; no bubbles while m_ready stays 1.
REQ-022 m_last=1 only on pixel (ROWS-1, COLS-1); ->IDLE on the edge that transfers it.
REQ-023 Coordinate arithmetic SHALL be signed and at least 2 bits wider than clog2 of the larger dimension; no truncation before range check.

Reset
REQ-024 rst SHALL force IDLE, s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0 immediately, in any state, including mid-LOAD or mid-EMIT.
REQ-025 Frame RAM contents SHALL NOT be reset; a partial frame SHALL be discarded.
REQ-026 In IDLE, s_ready SHALL be 1 from the first edge after rst deasserts.

Configuration
REQ-027 With macro IMAGE_TRANSLATE_WRAP_EN defined, SHALL implement REQ-020 modulo logic.
REQ-028 Without IMAGE_TRANSLATE_WRAP_EN, cfg_wrap SHALL be ignored and the block SHALL always fill per REQ-019.

Structure
REQ-029 Package image_pkg SHALL hold the state enum type, the shift width constant (16), and a clog2-based address width function.
REQ-030 Frame storage SHALL be sub-module frame_ram: simple dual-port, 1 write port, 1 synchronous read port with 1-cycle latency, depth ROWS*COLS, width DW.
REQ-031 The address generator, range/wrap logic, FSM and output register SHALL reside in image_translate_stream.

Verification (ROWS=COLS=4, DW=8, FILL=0, input pixel k = k for k=0..15)
REQ-032 dx=1, dy=0, wrap=0 -> row 0 out 0,0,1,2; row 3 out 0,12,13,14; m_last on the 16th beat only.
REQ-033 dx=-1, dy=1, wrap=1 (macro defined) -> row 0 out 13,14,15,12; row 1 out 1,2,3,0.
REQ-034 dy=4, wrap=0 -> all 16 outputs 0; dx=-5, dy=0, wrap=1 -> row 0 out 1,2,3,0.
REQ-035 m_ready toggled 1,0,0,1 repeatedly with dx=0, dy=0 -> output sequence 0..15 exact, m_data stable during each stall.
REQ-036 rst pulsed after 7 output beats, then a new frame with dx=0, dy=0 -> busy=0, m_valid=0 during rst; new output 0..15 with no stale beats.
REQ-037 cfg_dx changed 0->2 mid-LOAD with dx=0 latched -> output equals input unchanged.
